// File: rtl/cnt_ser_pkg.sv
// Shared definitions for the count snapshot serializer.
// Contents: the frame FSM state encoding, the frame and data bit counts,
// the line levels for idle, start and stop, and the even-parity helper.
package cnt_ser_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DIR    = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } state_t;

  // Frame layout: start + dir + 8 data + parity + stop.
  localparam int FRAME_BITS = 12;
  localparam int DATA_BITS  = 8;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  // Even parity over the direction bit and the data byte.
  function automatic logic even_parity(input logic d, input logic [DATA_BITS-1:0] v);
    return d ^ (^v);
  endfunction

endpackage

// File: rtl/count_bit_timer.sv
// Bit-period timer for the serializer.
// Ports:
//   clk     - system clock
//   rst     - synchronous, active-low reset
//   run     - timer counts while high, held at zero while low
//   bit_end - high during the last clock of each bit period
module count_bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic bit_end
);

  // One timer bit minimum so CLKS_PER_BIT = 1 still elaborates.
  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

  logic [TW-1:0] timer;

  assign bit_end = run && (timer == LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      timer <= '0;
    end else if (!run || bit_end) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end

endmodule

// File: rtl/count_snapshot_serializer.sv
// Captures the up/down counter value and direction on a snapshot request
// and shifts them out as a framed serial word on a single monitor pin:
// start(0), dir, count[7:0] MSB first, even parity, stop(1).
// Ports:
//   clk      - system clock, all logic on the rising edge
//   rst      - synchronous, active-low reset (aborts any frame)
//   count    - counter value to capture
//   dir      - counter direction (0 up, 1 down)
//   snap     - snapshot request, sampled every edge
//   ovr_clr  - clears the sticky overrun flag
//   tx       - registered serial line, idles high
//   busy     - registered, high while a frame is in progress
//   done     - one-cycle pulse in the first idle cycle after a frame
//   overrun  - sticky, set by snap while busy (set beats clear)
module count_snapshot_serializer
  import cnt_ser_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] count,
  input  logic       dir,
  input  logic       snap,
  input  logic       ovr_clr,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic       overrun
);

  state_t state, state_nxt;

  logic                 bit_end;
  logic                 accept;
  logic [2:0]           bit_idx, bit_idx_nxt;
  logic [DATA_BITS-1:0] sreg, sreg_nxt;
  logic                 dir_q;
  logic                 par_q;
  logic                 tx_nxt;
  logic                 busy_nxt;
  logic                 done_nxt;

  assign accept = (state == IDLE) && snap;

  count_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .run    (state != IDLE),
    .bit_end(bit_end)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      bit_idx <= '0;
    end else begin
      state   <= state_nxt;
      bit_idx <= bit_idx_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt   = state;
    bit_idx_nxt = bit_idx;
    case (state)
      IDLE:   if (snap) state_nxt = START;
      START:  if (bit_end) state_nxt = DIR;
      DIR: begin
        if (bit_end) begin
          state_nxt   = DATA;
          bit_idx_nxt = 3'(DATA_BITS - 1);
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx == 3'd0) state_nxt = PARITY;
          else                 bit_idx_nxt = bit_idx - 3'd1;
        end
      end
      PARITY: if (bit_end) state_nxt = STOP;
      STOP:   if (bit_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Shift register: load on capture, shift left at the end of each data bit.
  always_comb begin
    sreg_nxt = sreg;
    if (accept) begin
      sreg_nxt = count;
    end else if ((state == DATA) && bit_end) begin
      sreg_nxt = {sreg[DATA_BITS-2:0], 1'b0};
    end
  end

  // Output logic: computed from the next state so tx/busy can be registered
  // without adding a cycle of latency to the frame.
  always_comb begin
    tx_nxt = IDLE_LEVEL;
    case (state_nxt)
      START:   tx_nxt = START_LEVEL;
      DIR:     tx_nxt = dir_q;
      DATA:    tx_nxt = sreg_nxt[DATA_BITS-1];
      PARITY:  tx_nxt = par_q;
      STOP:    tx_nxt = STOP_LEVEL;
      default: tx_nxt = IDLE_LEVEL;
    endcase
    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state == STOP) && bit_end;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx      <= IDLE_LEVEL;
      busy    <= 1'b0;
      done    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      tx   <= tx_nxt;
      busy <= busy_nxt;
      done <= done_nxt;
      if (snap && busy) begin
        overrun <= 1'b1;
      end else if (ovr_clr) begin
        overrun <= 1'b0;
      end
    end
  end

  // Captured frame payload; only meaningful once a frame has been accepted.
  always_ff @(posedge clk) begin
    sreg <= sreg_nxt;
    if (accept) begin
      dir_q <= dir;
      par_q <= even_parity(dir, count);
    end
  end

endmodule

// File: tb/tb_count_snapshot_serializer.sv
module tb_count_snapshot_serializer;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] count;
  logic       dir;
  logic       snap;
  logic       ovr_clr;
  logic       tx;
  logic       busy;
  logic       done;
  logic       overrun;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  count_snapshot_serializer #(.CLKS_PER_BIT(CPB)) dut (
    .clk    (clk),
    .rst    (rst),
    .count  (count),
    .dir    (dir),
    .snap   (snap),
    .ovr_clr(ovr_clr),
    .tx     (tx),
    .busy   (busy),
    .done   (done),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  // Drive a snapshot request for one edge; returns just after the accept edge.
  task automatic start_snap(input logic [7:0] c, input logic d);
    count = c;
    dir   = d;
    snap  = 1'b1;
    @(posedge clk); #1;
  endtask

  // Observe a frame until busy falls. snap_at >= 0 pulses snap at that busy
  // cycle index, -1 keeps snap low, -2 leaves snap untouched.
  task automatic capture(input int snap_at, input bit wiggle,
                         output logic [11:0] bits, output int nbusy,
                         output logic stable, output logic mid_done,
                         output int ovr_first, output logic done_end);
    int b;
    bits = '0; nbusy = 0; stable = 1'b1; mid_done = 1'b0; ovr_first = -1;
    while (busy === 1'b1 && nbusy < 200) begin
      if (snap_at >= -1) snap = (nbusy == snap_at);
      if (wiggle) count = count + 8'd37;
      b = nbusy / CPB;
      if (b < 12) begin
        if (nbusy % CPB == 0) bits[11-b] = tx;
        else if (tx !== bits[11-b]) stable = 1'b0;
      end
      if (done === 1'b1) mid_done = 1'b1;
      if (overrun === 1'b1 && ovr_first < 0) ovr_first = nbusy;
      nbusy++;
      @(posedge clk); #1;
    end
    done_end = done;
  endtask

  task automatic test_reset();
    rst = 1'b0; count = 8'h00; dir = 1'b0; snap = 1'b0; ovr_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_cnt++; if (tx !== 1'b1) $display("FAIL reset_tx got %b exp 1", tx); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else pass_cnt++;
    chk_cnt++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else pass_cnt++;
    chk_cnt++; if (overrun !== 1'b0) $display("FAIL reset_overrun got %b exp 0", overrun); else pass_cnt++;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [11:0] bits; int nb; logic st, md, de; int of;
    start_snap(8'hA5, 1'b0);
    capture(-1, 1'b0, bits, nb, st, md, of, de);
    chk_cnt++; if (bits !== 12'b001010010101) $display("FAIL a5_bits got %b exp 001010010101", bits); else pass_cnt++;
    chk_cnt++; if (st !== 1'b1) $display("FAIL a5_bit_hold got %b exp 1", st); else pass_cnt++;
    chk_cnt++; if (nb != 48) $display("FAIL a5_busy_len got %0d exp 48", nb); else pass_cnt++;
    chk_cnt++; if (md !== 1'b0) $display("FAIL a5_early_done got %b exp 0", md); else pass_cnt++;
    chk_cnt++; if (de !== 1'b1) $display("FAIL a5_done got %b exp 1", de); else pass_cnt++;
    chk_cnt++; if (tx !== 1'b1) $display("FAIL a5_idle_tx got %b exp 1", tx); else pass_cnt++;
    @(posedge clk); #1;
    chk_cnt++; if (done !== 1'b0) $display("FAIL a5_done_width got %b exp 0", done); else pass_cnt++;
  endtask

  task automatic test_wrap();
    logic [11:0] bits; int nb; logic st, md, de; int of;
    start_snap(8'h00, 1'b1);
    capture(-1, 1'b0, bits, nb, st, md, of, de);
    chk_cnt++; if (bits !== 12'b010000000011) $display("FAIL w00_bits got %b exp 010000000011", bits); else pass_cnt++;
    chk_cnt++; if (st !== 1'b1 || nb != 48) $display("FAIL w00_timing got hold=%b len=%0d exp hold=1 len=48", st, nb); else pass_cnt++;
    @(posedge clk); #1;
    start_snap(8'hFF, 1'b0);
    capture(-1, 1'b0, bits, nb, st, md, of, de);
    chk_cnt++; if (bits !== 12'b001111111101) $display("FAIL wff_bits got %b exp 001111111101", bits); else pass_cnt++;
    chk_cnt++; if (de !== 1'b1) $display("FAIL wff_done got %b exp 1", de); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_count_change();
    logic [11:0] bits; int nb; logic st, md, de; int of;
    start_snap(8'h3C, 1'b1);
    capture(-1, 1'b1, bits, nb, st, md, of, de);
    chk_cnt++; if (bits !== 12'b010011110011) $display("FAIL capture_only got %b exp 010011110011", bits); else pass_cnt++;
    chk_cnt++; if (st !== 1'b1) $display("FAIL capture_hold got %b exp 1", st); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_overrun();
    logic [11:0] bits; int nb; logic st, md, de; int of;
    chk_cnt++; if (overrun !== 1'b0) $display("FAIL ovr_initial got %b exp 0", overrun); else pass_cnt++;
    start_snap(8'h5A, 1'b0);
    capture(10, 1'b0, bits, nb, st, md, of, de);
    chk_cnt++; if (of != 11) $display("FAIL ovr_set_cycle got %0d exp 11", of); else pass_cnt++;
    chk_cnt++; if (bits !== 12'b000101101001) $display("FAIL ovr_frame got %b exp 000101101001", bits); else pass_cnt++;
    chk_cnt++; if (nb != 48) $display("FAIL ovr_frame_len got %0d exp 48", nb); else pass_cnt++;
    chk_cnt++; if (overrun !== 1'b1) $display("FAIL ovr_sticky got %b exp 1", overrun); else pass_cnt++;
    ovr_clr = 1'b1;
    @(posedge clk); #1;
    ovr_clr = 1'b0;
    chk_cnt++; if (overrun !== 1'b0) $display("FAIL ovr_clr_idle got %b exp 0", overrun); else pass_cnt++;
    start_snap(8'h01, 1'b0);
    snap = 1'b1; ovr_clr = 1'b1;
    @(posedge clk); #1;
    chk_cnt++; if (overrun !== 1'b1) $display("FAIL ovr_set_wins got %b exp 1", overrun); else pass_cnt++;
    snap = 1'b0; ovr_clr = 1'b1;
    @(posedge clk); #1;
    ovr_clr = 1'b0;
    chk_cnt++; if (overrun !== 1'b0) $display("FAIL ovr_clr_busy got %b exp 0", overrun); else pass_cnt++;
    capture(-1, 1'b0, bits, nb, st, md, of, de);
    chk_cnt++; if (de !== 1'b1) $display("FAIL ovr_frame2_done got %b exp 1", de); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [11:0] bits; int nb; logic st, md, de; int of;
    start_snap(8'hA5, 1'b0);
    capture(-2, 1'b0, bits, nb, st, md, of, de);
    chk_cnt++; if (bits !== 12'b001010010101 || nb != 48) $display("FAIL b2b_frame1 got %b len=%0d exp 001010010101 len=48", bits, nb); else pass_cnt++;
    chk_cnt++; if (of != 1) $display("FAIL b2b_ovr_cycle got %0d exp 1", of); else pass_cnt++;
    chk_cnt++; if (de !== 1'b1 || busy !== 1'b0) $display("FAIL b2b_gap got done=%b busy=%b exp done=1 busy=0", de, busy); else pass_cnt++;
    @(posedge clk); #1;
    chk_cnt++; if (busy !== 1'b1 || tx !== 1'b0) $display("FAIL b2b_restart got busy=%b tx=%b exp busy=1 tx=0", busy, tx); else pass_cnt++;
    capture(-2, 1'b0, bits, nb, st, md, of, de);
    snap = 1'b0;
    chk_cnt++; if (bits !== 12'b001010010101 || nb != 48) $display("FAIL b2b_frame2 got %b len=%0d exp 001010010101 len=48", bits, nb); else pass_cnt++;
    chk_cnt++; if (de !== 1'b1) $display("FAIL b2b_done2 got %b exp 1", de); else pass_cnt++;
    @(posedge clk); #1;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL b2b_stop got %b exp 0", busy); else pass_cnt++;
    ovr_clr = 1'b1;
    @(posedge clk); #1;
    ovr_clr = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [11:0] bits; int nb; logic st, md, de; int of;
    logic stray;
    start_snap(8'hA5, 1'b0);
    for (int i = 0; i < 15; i++) begin
      snap = (i == 2);
      @(posedge clk); #1;
    end
    chk_cnt++; if (overrun !== 1'b1 || busy !== 1'b1) $display("FAIL rmid_pre got ovr=%b busy=%b exp 1 1", overrun, busy); else pass_cnt++;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk_cnt++; if (tx !== 1'b1) $display("FAIL rmid_tx got %b exp 1", tx); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL rmid_busy got %b exp 0", busy); else pass_cnt++;
    chk_cnt++; if (overrun !== 1'b0) $display("FAIL rmid_overrun got %b exp 0", overrun); else pass_cnt++;
    stray = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (done !== 1'b0 || busy !== 1'b0 || tx !== 1'b1) stray = 1'b1;
      @(posedge clk); #1;
    end
    chk_cnt++; if (stray !== 1'b0) $display("FAIL rmid_no_done got %b exp 0", stray); else pass_cnt++;
    start_snap(8'hC3, 1'b1);
    capture(-1, 1'b0, bits, nb, st, md, of, de);
    chk_cnt++; if (bits !== 12'b011100001111) $display("FAIL rmid_clean got %b exp 011100001111", bits); else pass_cnt++;
    chk_cnt++; if (nb != 48 || st !== 1'b1 || de !== 1'b1) $display("FAIL rmid_clean_timing got len=%0d hold=%b done=%b exp 48 1 1", nb, st, de); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_count_change();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
